// File: rtl/riscv_pipe_pkg.sv
// riscv_pipe_pkg: shared types and per-class stage control words for the pipeline hazard controller
package riscv_pipe_pkg;
  typedef enum logic [1:0] {IDLE, GRANT_WAIT, DATA_WAIT} dmem_state_t;
  typedef struct packed {
    logic [4:0] en;
    logic [3:0] clr;
  } stage_ctrl_t;
  localparam stage_ctrl_t C_RESET  = '{en: 5'b00000, clr: 4'b1111};
  localparam stage_ctrl_t C_MEM    = '{en: 5'b00001, clr: 4'b0001};
  localparam stage_ctrl_t C_BR_IW  = '{en: 5'b00011, clr: 4'b0010};
  localparam stage_ctrl_t C_BRANCH = '{en: 5'b11111, clr: 4'b1100};
  localparam stage_ctrl_t C_LOAD   = '{en: 5'b00111, clr: 4'b0100};
  localparam stage_ctrl_t C_IWAIT  = '{en: 5'b01111, clr: 4'b1000};
  localparam stage_ctrl_t C_RUN    = '{en: 5'b11111, clr: 4'b0000};
endpackage

// File: rtl/dmem_wait_fsm.sv
// dmem_wait_fsm: Avalon data-master wait tracking with bus timeout; yields mem_stall, dmem_req_en, timeout_evt
module dmem_wait_fsm
  import riscv_pipe_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic CLK,
  input  logic RST,
  input  logic dmem_read,
  input  logic dmem_write,
  input  logic dmem_waitrequest,
  input  logic dmem_readdatavalid,
  output logic mem_stall,
  output logic dmem_req_en,
  output logic timeout_evt
);
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  dmem_state_t r_state;
  dmem_state_t w_next;
  logic [TW-1:0] r_cnt;
  logic w_act;
  assign w_act = r_state == GRANT_WAIT || dmem_read || dmem_write;
  assign timeout_evt = r_state != IDLE && r_cnt == TW'(TIMEOUT_CYCLES - 1);
  assign dmem_req_en = r_state != DATA_WAIT;
  always_comb begin
    mem_stall = timeout_evt ? 1'b0 :
                r_state == DATA_WAIT ? !dmem_readdatavalid :
                w_act && (dmem_waitrequest || dmem_read);
    w_next = timeout_evt ? IDLE :
             r_state == DATA_WAIT ? (dmem_readdatavalid ? IDLE : DATA_WAIT) :
             !w_act ? IDLE :
             dmem_waitrequest ? GRANT_WAIT :
             dmem_read ? DATA_WAIT : IDLE;
  end
  always_ff @(posedge CLK) begin
    r_state <= RST ? IDLE : w_next;
    r_cnt   <= (RST || r_state == IDLE || w_next != r_state) ? '0 : r_cnt + 1'b1;
  end
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush priority decode for the 5-stage pipeline plus bus_error and stall counter
module pipeline_hazard_ctrl
  import riscv_pipe_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [4:0]       ID_rs1,
  input  logic [4:0]       ID_rs2,
  input  logic             ID_use_rs2,
  input  logic [4:0]       EX_rd,
  input  logic             EX_MemRead,
  input  logic             EX_branch_taken,
  input  logic             imem_waitrequest,
  input  logic             dmem_read,
  input  logic             dmem_write,
  input  logic             dmem_waitrequest,
  input  logic             dmem_readdatavalid,
  output logic             dmem_req_en,
  output logic             en_PC,
  output logic             en_IFID,
  output logic             en_IDEX,
  output logic             en_EXMEM,
  output logic             en_MEMWB,
  output logic             clr_IFID,
  output logic             clr_IDEX,
  output logic             clr_EXMEM,
  output logic             clr_MEMWB,
  output logic             bus_error,
  output logic [CNT_W-1:0] stall_cycles
);
  logic w_mem_stall;
  logic w_req_en;
  logic w_timeout;
  logic w_load_use;
  stage_ctrl_t w_ctrl;
  logic r_bus_error;
  logic [CNT_W-1:0] r_stall_cycles;
  dmem_wait_fsm #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_fsm (
    .CLK(CLK),
    .RST(RST),
    .dmem_read(dmem_read),
    .dmem_write(dmem_write),
    .dmem_waitrequest(dmem_waitrequest),
    .dmem_readdatavalid(dmem_readdatavalid),
    .mem_stall(w_mem_stall),
    .dmem_req_en(w_req_en),
    .timeout_evt(w_timeout)
  );
  assign w_load_use = EX_MemRead && EX_rd != 5'd0 &&
                      (EX_rd == ID_rs1 || (ID_use_rs2 && EX_rd == ID_rs2));
  always_comb begin
    w_ctrl = RST ? C_RESET :
             w_mem_stall ? C_MEM :
             (EX_branch_taken && imem_waitrequest) ? C_BR_IW :
             EX_branch_taken ? C_BRANCH :
             w_load_use ? C_LOAD :
             imem_waitrequest ? C_IWAIT : C_RUN;
  end
  assign {en_PC, en_IFID, en_IDEX, en_EXMEM, en_MEMWB} = w_ctrl.en;
  assign {clr_IFID, clr_IDEX, clr_EXMEM, clr_MEMWB} = w_ctrl.clr;
  assign dmem_req_en = w_req_en && !RST;
  assign bus_error = r_bus_error;
  assign stall_cycles = r_stall_cycles;
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_bus_error    <= 1'b0;
      r_stall_cycles <= '0;
    end else begin
      if (w_timeout) r_bus_error <= 1'b1;
      if (!en_PC && r_stall_cycles != '1) r_stall_cycles <= r_stall_cycles + 1'b1;
    end
  end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: scenario-driven scoreboard bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;
  logic CLK, RST, ID_use_rs2, EX_MemRead, EX_branch_taken, imem_waitrequest;
  logic dmem_read, dmem_write, dmem_waitrequest, dmem_readdatavalid;
  logic [4:0] ID_rs1, ID_rs2, EX_rd;
  logic dmem_req_en, en_PC, en_IFID, en_IDEX, en_EXMEM, en_MEMWB;
  logic clr_IFID, clr_IDEX, clr_EXMEM, clr_MEMWB, bus_error;
  logic [5:0] stall_cycles;
  logic [16:0] obs;
  logic [16:0] sb[$];
  logic [5:0] m_sc;
  logic m_berr;
  int total, bad;
  typedef struct packed {
    logic [6:0] b;
    logic ld;
    logic u2;
    logic [4:0] exrd;
    logic [4:0] rs1;
    logic [4:0] rs2;
  } stim_t;
  localparam logic [9:0] NRM1 = 10'b11111_0000_1;
  localparam logic [9:0] NRM0 = 10'b11111_0000_0;
  localparam logic [9:0] RSTV = 10'b00000_1111_0;
  localparam logic [9:0] MEM1 = 10'b00001_0001_1;
  localparam logic [9:0] MEM0 = 10'b00001_0001_0;
  localparam logic [9:0] BRW  = 10'b00011_0010_1;
  localparam logic [9:0] BRT  = 10'b11111_1100_1;
  localparam logic [9:0] LDU  = 10'b00111_0100_1;
  localparam logic [9:0] IMW  = 10'b01111_1000_1;
  pipeline_hazard_ctrl #(.TIMEOUT_CYCLES(8), .CNT_W(6)) dut (
    .CLK(CLK), .RST(RST), .ID_rs1(ID_rs1), .ID_rs2(ID_rs2), .ID_use_rs2(ID_use_rs2),
    .EX_rd(EX_rd), .EX_MemRead(EX_MemRead), .EX_branch_taken(EX_branch_taken),
    .imem_waitrequest(imem_waitrequest), .dmem_read(dmem_read), .dmem_write(dmem_write),
    .dmem_waitrequest(dmem_waitrequest), .dmem_readdatavalid(dmem_readdatavalid),
    .dmem_req_en(dmem_req_en), .en_PC(en_PC), .en_IFID(en_IFID), .en_IDEX(en_IDEX),
    .en_EXMEM(en_EXMEM), .en_MEMWB(en_MEMWB), .clr_IFID(clr_IFID), .clr_IDEX(clr_IDEX),
    .clr_EXMEM(clr_EXMEM), .clr_MEMWB(clr_MEMWB), .bus_error(bus_error),
    .stall_cycles(stall_cycles)
  );
  assign obs = {en_PC, en_IFID, en_IDEX, en_EXMEM, en_MEMWB, clr_IFID, clr_IDEX,
                clr_EXMEM, clr_MEMWB, dmem_req_en, bus_error, stall_cycles};
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  function automatic stim_t mk(logic [6:0] b, logic ld, logic u2, logic [4:0] exrd,
                               logic [4:0] rs1, logic [4:0] rs2);
    return '{b: b, ld: ld, u2: u2, exrd: exrd, rs1: rs1, rs2: rs2};
  endfunction
  function automatic stim_t z(logic [6:0] b);
    return mk(b, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
  endfunction
  task automatic apply(input stim_t s);
    {RST, EX_branch_taken, imem_waitrequest, dmem_read, dmem_write,
     dmem_waitrequest, dmem_readdatavalid} = s.b;
    EX_MemRead = s.ld;
    ID_use_rs2 = s.u2;
    EX_rd = s.exrd;
    ID_rs1 = s.rs1;
    ID_rs2 = s.rs2;
  endtask
  function automatic logic [5:0] next_sc(input logic rst, input logic pc_en, input logic [5:0] sc);
    return rst ? 6'd0 : (!pc_en && sc != 6'h3f) ? sc + 6'd1 : sc;
  endfunction
  task automatic test_reset;
    stim_t st[3];
    logic [9:0] ex[3];
    logic [16:0] e;
    st = '{z(7'b1000000), z(7'b1000000), z(7'b0000000)};
    ex = '{RSTV, RSTV, NRM1};
    foreach (st[k]) begin
      apply(st[k]);
      sb.push_back({ex[k], m_berr, m_sc});
      @(negedge CLK);
      e = sb.pop_front();
      total++;
      if (obs !== e) begin bad++; $display("FAIL reset[%0d] got=%h want=%h", k, obs, e); end
      m_sc = next_sc(st[k].b[6], ex[k][9], m_sc);
      if (st[k].b[6]) m_berr = 1'b0;
      @(posedge CLK); #1;
    end
  endtask
  task automatic test_load_use;
    stim_t st[7];
    logic [9:0] ex[7];
    logic [16:0] e;
    st = '{mk(7'b0, 1, 0, 5'd5, 5'd5, 5'd0), z(7'b0), mk(7'b0, 1, 0, 5'd0, 5'd0, 5'd0),
           mk(7'b0, 1, 1, 5'd7, 5'd1, 5'd7), mk(7'b0, 1, 0, 5'd7, 5'd1, 5'd7),
           mk(7'b0010000, 1, 0, 5'd9, 5'd9, 5'd0), mk(7'b0, 0, 0, 5'd9, 5'd9, 5'd0)};
    ex = '{LDU, NRM1, NRM1, LDU, NRM1, LDU, NRM1};
    foreach (st[k]) begin
      apply(st[k]);
      sb.push_back({ex[k], m_berr, m_sc});
      @(negedge CLK);
      e = sb.pop_front();
      total++;
      if (obs !== e) begin bad++; $display("FAIL load_use[%0d] got=%h want=%h", k, obs, e); end
      m_sc = next_sc(st[k].b[6], ex[k][9], m_sc);
      @(posedge CLK); #1;
    end
  endtask
  task automatic test_read;
    stim_t st[5];
    logic [9:0] ex[5];
    logic [16:0] e;
    st = '{z(7'b0001000), z(7'b0101000), z(7'b0001000), z(7'b0000001), z(7'b0000000)};
    ex = '{MEM1, MEM0, MEM0, NRM0, NRM1};
    foreach (st[k]) begin
      apply(st[k]);
      sb.push_back({ex[k], m_berr, m_sc});
      @(negedge CLK);
      e = sb.pop_front();
      total++;
      if (obs !== e) begin bad++; $display("FAIL read[%0d] got=%h want=%h", k, obs, e); end
      m_sc = next_sc(st[k].b[6], ex[k][9], m_sc);
      @(posedge CLK); #1;
    end
  endtask
  task automatic test_write_wait;
    stim_t st[9];
    logic [9:0] ex[9];
    logic [16:0] e;
    st = '{z(7'b0000110), z(7'b0000110), z(7'b0000100), z(7'b0000000), z(7'b0001010),
           z(7'b0001000), z(7'b0000001), z(7'b0000000), z(7'b0000100)};
    ex = '{MEM1, MEM1, NRM1, NRM1, MEM1, MEM1, NRM0, NRM1, NRM1};
    foreach (st[k]) begin
      apply(st[k]);
      sb.push_back({ex[k], m_berr, m_sc});
      @(negedge CLK);
      e = sb.pop_front();
      total++;
      if (obs !== e) begin bad++; $display("FAIL write_wait[%0d] got=%h want=%h", k, obs, e); end
      m_sc = next_sc(st[k].b[6], ex[k][9], m_sc);
      @(posedge CLK); #1;
    end
  endtask
  task automatic test_branch;
    stim_t st[6];
    logic [9:0] ex[6];
    logic [16:0] e;
    st = '{z(7'b0110000), z(7'b0110000), z(7'b0100000), z(7'b0000000), z(7'b0010000), z(7'b0000000)};
    ex = '{BRW, BRW, BRT, NRM1, IMW, NRM1};
    foreach (st[k]) begin
      apply(st[k]);
      sb.push_back({ex[k], m_berr, m_sc});
      @(negedge CLK);
      e = sb.pop_front();
      total++;
      if (obs !== e) begin bad++; $display("FAIL branch[%0d] got=%h want=%h", k, obs, e); end
      m_sc = next_sc(st[k].b[6], ex[k][9], m_sc);
      @(posedge CLK); #1;
    end
  endtask
  task automatic test_timeout;
    logic [16:0] e;
    for (int k = 0; k < 11; k++) begin
      apply(z(k < 9 ? 7'b0000110 : 7'b0000000));
      sb.push_back({(k < 8 ? MEM1 : NRM1), m_berr, m_sc});
      @(negedge CLK);
      e = sb.pop_front();
      total++;
      if (obs !== e) begin bad++; $display("FAIL timeout[%0d] got=%h want=%h", k, obs, e); end
      m_sc = next_sc(1'b0, e[16], m_sc);
      if (k == 8) m_berr = 1'b1;
      @(posedge CLK); #1;
    end
  endtask
  task automatic test_saturation;
    logic [16:0] e;
    for (int k = 0; k < 50; k++) begin
      apply(z(7'b0010000));
      sb.push_back({IMW, m_berr, m_sc});
      @(negedge CLK);
      e = sb.pop_front();
      total++;
      if (obs !== e) begin bad++; $display("FAIL saturation[%0d] got=%h want=%h", k, obs, e); end
      m_sc = next_sc(1'b0, 1'b0, m_sc);
      @(posedge CLK); #1;
    end
    apply(z(7'b0));
    @(negedge CLK);
    total++;
    if (stall_cycles !== 6'h3f) begin bad++; $display("FAIL sat_hold got=%0d want=63", stall_cycles); end
    @(posedge CLK); #1;
  endtask
  task automatic test_reset_mid;
    stim_t st[5];
    logic [9:0] ex[5];
    logic [16:0] e;
    st = '{z(7'b0001000), z(7'b0001000), z(7'b1000000), z(7'b1000000), z(7'b0000000)};
    ex = '{MEM1, MEM0, RSTV, RSTV, NRM1};
    foreach (st[k]) begin
      apply(st[k]);
      sb.push_back({ex[k], m_berr, m_sc});
      @(negedge CLK);
      e = sb.pop_front();
      total++;
      if (obs !== e) begin bad++; $display("FAIL reset_mid[%0d] got=%h want=%h", k, obs, e); end
      m_sc = next_sc(st[k].b[6], ex[k][9], m_sc);
      if (st[k].b[6]) m_berr = 1'b0;
      @(posedge CLK); #1;
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    total = 0;
    bad = 0;
    m_sc = 6'd0;
    m_berr = 1'b0;
    apply(z(7'b1000000));
    @(posedge CLK); #1;
    test_reset;
    test_load_use;
    test_read;
    test_write_wait;
    test_branch;
    test_timeout;
    test_saturation;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
